// File: rtl/led_seq_pkg.sv
// Shared constants and helpers for the LED pattern sequencer.
package led_seq_pkg;

    // Pattern selected on the MODE input and latched on a tick.
    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_CHASE  = 2'd2,
        MODE_BOUNCE = 2'd3
    } mode_e;

    localparam int NUM_LEDS = 4;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // One BOUNCE step: returns {new_dir, new_pos}; reverses at both ends.
    function automatic logic [2:0] bounce_step(input logic [1:0] pos, input logic dir);
        logic [2:0] res;
        res = {dir, pos};
        if (dir == DIR_UP) begin
            if (pos == 2'd3) begin
                res = {DIR_DOWN, 2'd2};
            end else begin
                res = {DIR_UP, pos + 2'd1};
            end
        end else begin
            if (pos == 2'd0) begin
                res = {DIR_UP, 2'd1};
            end else begin
                res = {DIR_DOWN, pos - 2'd1};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One PWM channel: registered compare of a brightness level against the
// shared PWM counter.
module led_pwm_channel #(
    parameter int PWM_BITS = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [PWM_BITS-1:0] i_level,
    input  logic [PWM_BITS-1:0] i_pwm_cnt,
    output logic                o_led
);

    logic r_led;

    // LED is on while the level exceeds the counter; level 0 is always off.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_led <= 1'b0;
        end else begin
            r_led <= (i_level > i_pwm_cnt);
        end
    end

    assign o_led = r_led;

endmodule

// File: rtl/led_sequencer.sv
// Animated LED pattern sequencer: steps a pattern FSM on each prescaler
// tick and renders the four brightness levels through shared-counter PWM.
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int PWM_BITS = 4
) (
    input  logic       CLKIN,
    input  logic       RESET,
    input  logic       TICK,
    input  logic [1:0] MODE,
    output logic       D2,
    output logic       D3,
    output logic       D4,
    output logic       D5
);

    localparam logic [PWM_BITS-1:0] MAX_LEVEL = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] ZERO_LVL  = {PWM_BITS{1'b0}};
    localparam logic [PWM_BITS-1:0] PWM_ONE   = {{(PWM_BITS-1){1'b0}}, 1'b1};

    mode_e               r_mode_q;
    mode_e               w_mode_next;
    mode_e               w_mode_in;
    logic [1:0]          r_pos;
    logic [1:0]          w_pos_next;
    logic                r_dir;
    logic                w_dir_next;
    logic                r_phase;
    logic                w_phase_next;
    logic [2:0]          w_bounce;
    logic [PWM_BITS-1:0] r_level      [NUM_LEDS];
    logic [PWM_BITS-1:0] w_level_next [NUM_LEDS];
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [NUM_LEDS-1:0] w_led;

    assign w_mode_in = mode_e'(MODE);
    assign w_bounce  = bounce_step(r_pos, r_dir);

    // Pattern state register; all pattern state holds unless next-state logic changes it.
    always_ff @(posedge CLKIN or posedge RESET) begin
        if (RESET) begin
            r_mode_q <= MODE_OFF;
            r_pos    <= 2'd0;
            r_dir    <= DIR_UP;
            r_phase  <= 1'b0;
            for (int i = 0; i < NUM_LEDS; i++) begin
                r_level[i] <= ZERO_LVL;
            end
        end else begin
            r_mode_q <= w_mode_next;
            r_pos    <= w_pos_next;
            r_dir    <= w_dir_next;
            r_phase  <= w_phase_next;
            for (int i = 0; i < NUM_LEDS; i++) begin
                r_level[i] <= w_level_next[i];
            end
        end
    end

    // Next-state: a tick either latches a new mode (clearing everything) or takes one pattern step.
    always_comb begin
        w_mode_next  = r_mode_q;
        w_pos_next   = r_pos;
        w_dir_next   = r_dir;
        w_phase_next = r_phase;
        for (int i = 0; i < NUM_LEDS; i++) begin
            w_level_next[i] = r_level[i];
        end

        if (TICK) begin
            if (w_mode_in != r_mode_q) begin
                w_mode_next  = w_mode_in;
                w_pos_next   = 2'd0;
                w_dir_next   = DIR_UP;
                w_phase_next = 1'b0;
                for (int i = 0; i < NUM_LEDS; i++) begin
                    w_level_next[i] = ZERO_LVL;
                end
            end else begin
                case (r_mode_q)
                    MODE_OFF: begin
                        for (int i = 0; i < NUM_LEDS; i++) begin
                            w_level_next[i] = ZERO_LVL;
                        end
                    end
                    MODE_BLINK: begin
                        w_phase_next = ~r_phase;
                        for (int i = 0; i < NUM_LEDS; i++) begin
                            w_level_next[i] = w_phase_next ? MAX_LEVEL : ZERO_LVL;
                        end
                    end
                    MODE_CHASE: begin
                        w_pos_next = r_pos + 2'd1;
                        for (int i = 0; i < NUM_LEDS; i++) begin
                            w_level_next[i] = (w_pos_next == 2'(i)) ? MAX_LEVEL : ZERO_LVL;
                        end
                    end
                    MODE_BOUNCE: begin
                        w_dir_next = w_bounce[2];
                        w_pos_next = w_bounce[1:0];
                        // Head at full brightness, the rest halve each step to form a fading tail.
                        for (int i = 0; i < NUM_LEDS; i++) begin
                            w_level_next[i] = (w_pos_next == 2'(i)) ? MAX_LEVEL : (r_level[i] >> 1);
                        end
                    end
                    default: begin
                        for (int i = 0; i < NUM_LEDS; i++) begin
                            w_level_next[i] = ZERO_LVL;
                        end
                    end
                endcase
            end
        end else begin
            w_mode_next = r_mode_q;
        end
    end

    // Free-running PWM counter shared by all channels; wraps naturally at MAX.
    always_ff @(posedge CLKIN or posedge RESET) begin
        if (RESET) begin
            r_pwm_cnt <= ZERO_LVL;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + PWM_ONE;
        end
    end

    for (genvar g = 0; g < NUM_LEDS; g++) begin : g_chan
        led_pwm_channel #(
            .PWM_BITS (PWM_BITS)
        ) u_chan (
            .i_clk     (CLKIN),
            .i_rst     (RESET),
            .i_level   (r_level[g]),
            .i_pwm_cnt (r_pwm_cnt),
            .o_led     (w_led[g])
        );
    end

    assign D2 = w_led[0];
    assign D3 = w_led[1];
    assign D4 = w_led[2];
    assign D5 = w_led[3];

endmodule

// File: tb/tb_led_sequencer.sv
// Self-checking bench for led_sequencer: directed pattern checks plus
// randomized ticks/modes against a step-count based behavioural model.
module tb_led_sequencer;

    localparam int MAXL = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic [1:0] mode = 2'd0;
    logic       d2, d3, d4, d5;

    int total = 0;
    int bad   = 0;

    // Behavioural model: pattern derived from number of steps since mode latch.
    int       m_mode = 0;
    int       m_k    = 0;
    int       m_pwm  = 0;
    int       m_lvl [4] = '{0, 0, 0, 0};
    logic [3:0] exp_d = 4'd0;
    int       bseq [6] = '{0, 1, 2, 3, 2, 1};

    led_sequencer #(.PWM_BITS(4)) dut (
        .CLKIN (clk),
        .RESET (rst),
        .TICK  (tick),
        .MODE  (mode),
        .D2    (d2),
        .D3    (d3),
        .D4    (d4),
        .D5    (d5)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model update on every clock edge; reset clears it immediately.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = 0; m_k = 0; m_pwm = 0; exp_d = 4'd0;
            for (int j = 0; j < 4; j++) m_lvl[j] = 0;
        end else begin
            for (int j = 0; j < 4; j++) exp_d[j] = (m_lvl[j] > m_pwm);
            m_pwm = (m_pwm + 1) % 16;
            if (tick) begin
                if (int'(mode) != m_mode) begin
                    m_mode = int'(mode);
                    m_k = 0;
                    for (int j = 0; j < 4; j++) m_lvl[j] = 0;
                end else begin
                    m_k++;
                    case (m_mode)
                        1: for (int j = 0; j < 4; j++) m_lvl[j] = (m_k % 2 == 1) ? MAXL : 0;
                        2: for (int j = 0; j < 4; j++) m_lvl[j] = (j == m_k % 4) ? MAXL : 0;
                        3: for (int j = 0; j < 4; j++) m_lvl[j] = (j == bseq[m_k % 6]) ? MAXL : m_lvl[j] / 2;
                        default: for (int j = 0; j < 4; j++) m_lvl[j] = 0;
                    endcase
                end
            end
        end
    end

    // Per-cycle comparison of outputs, PWM counter and levels against the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("leds", {28'd0, d5, d4, d3, d2}, {28'd0, exp_d});
            chk("pwm_cnt", 32'(dut.r_pwm_cnt), 32'(m_pwm));
            for (int j = 0; j < 4; j++) chk("level", 32'(dut.r_level[j]), 32'(m_lvl[j]));
        end
    end

    task automatic do_tick(input logic [1:0] m);
        @(negedge clk);
        mode = m;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic chk_lv(input string nm, input int a, input int b, input int c, input int d);
        int e [4];
        e = '{a, b, c, d};
        for (int j = 0; j < 4; j++) begin
            chk({nm, "_model"}, 32'(m_lvl[j]), 32'(e[j]));
            chk({nm, "_dut"}, 32'(dut.r_level[j]), 32'(e[j]));
        end
    endtask

    initial begin
        int cnt [4];
        int burst;
        int cpos [6];
        cpos = '{1, 2, 3, 0, 1, 2};
        burst = 0;

        // Reset, then 64 cycles of OFF with pulsing ticks: LEDs stay dark.
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            tick = (i % 3 == 0);
            chk("off_dark", {28'd0, d5, d4, d3, d2}, 32'd0);
        end
        tick = 1'b0;
        chk("off_mode", 32'(dut.r_mode_q), 32'd0);

        // BLINK: latch, on, off.
        do_tick(2'd1);
        chk_lv("blink_latch", 0, 0, 0, 0);
        chk("blink_mode", 32'(dut.r_mode_q), 32'd1);
        do_tick(2'd1);
        chk_lv("blink_on", MAXL, MAXL, MAXL, MAXL);
        chk("blink_delay", {28'd0, d5, d4, d3, d2}, 32'd0);
        cnt = '{0, 0, 0, 0};
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            cnt[0] += int'(d2); cnt[1] += int'(d3); cnt[2] += int'(d4); cnt[3] += int'(d5);
        end
        for (int j = 0; j < 4; j++) chk("blink_duty", 32'(cnt[j]), 32'd15);
        do_tick(2'd1);
        chk_lv("blink_off", 0, 0, 0, 0);

        // CHASE: six steps after latch.
        do_tick(2'd2);
        chk_lv("chase_latch", 0, 0, 0, 0);
        for (int k = 0; k < 6; k++) begin
            do_tick(2'd2);
            for (int j = 0; j < 4; j++) begin
                chk("chase_model", 32'(m_lvl[j]), (j == cpos[k]) ? 32'd15 : 32'd0);
                chk("chase_dut", 32'(dut.r_level[j]), (j == cpos[k]) ? 32'd15 : 32'd0);
            end
        end

        // Mode switch between ticks is ignored until the next tick.
        @(negedge clk);
        mode = 2'd1;
        repeat (5) @(negedge clk);
        chk_lv("switch_hold", 0, 0, MAXL, 0);
        do_tick(2'd1);
        chk_lv("switch_latch", 0, 0, 0, 0);
        chk("switch_pos", 32'(dut.r_pos), 32'd0);
        do_tick(2'd1);
        chk_lv("switch_on", MAXL, MAXL, MAXL, MAXL);

        // BOUNCE: head with fading tail, reversal at the top.
        do_tick(2'd3);
        chk_lv("bounce_latch", 0, 0, 0, 0);
        do_tick(2'd3);
        chk_lv("bounce1", 0, 15, 0, 0);
        do_tick(2'd3);
        chk_lv("bounce2", 0, 7, 15, 0);
        do_tick(2'd3);
        chk_lv("bounce3", 0, 3, 7, 15);
        do_tick(2'd3);
        chk_lv("bounce4", 0, 1, 15, 7);
        chk("bounce_dir", 32'(dut.r_dir), 32'd1);
        do_tick(2'd3);
        chk_lv("bounce5", 0, 15, 7, 3);

        // Async reset mid-BOUNCE, with a tick coincident with reset.
        @(negedge clk);
        #2 rst = 1'b1;
        tick = 1'b1;
        #1;
        chk("rst_leds", {28'd0, d5, d4, d3, d2}, 32'd0);
        chk("rst_pwm", 32'(dut.r_pwm_cnt), 32'd0);
        chk("rst_mode", 32'(dut.r_mode_q), 32'd0);
        chk("rst_pos", 32'(dut.r_pos), 32'd0);
        chk("rst_dir", 32'(dut.r_dir), 32'd0);
        chk("rst_phase", 32'(dut.r_phase), 32'd0);
        for (int j = 0; j < 4; j++) chk("rst_level", 32'(dut.r_level[j]), 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        tick = 1'b0;
        #1;
        chk("rst_tick_lost", 32'(dut.r_mode_q), 32'd0);

        // Randomized ticks, held-tick bursts, mode changes and one reset pulse.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
            if (burst > 0) begin
                tick = 1'b1;
                burst--;
            end else if ($urandom_range(0, 49) == 0) begin
                burst = $urandom_range(2, 12);
                tick = 1'b1;
            end else begin
                tick = ($urandom_range(0, 5) == 0);
            end
            if (c == 1700) begin
                #3 rst = 1'b1;
                #4 rst = 1'b0;
            end
        end
        @(negedge clk);
        tick = 1'b0;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_sequencer.md
# led_sequencer

Drives the four board LEDs (D2–D5) with animated, brightness-controlled patterns on the HX8K board. It sits directly downstream of the free-running prescaler counter and consumes that counter's carry-out as a one-cycle step tick. Each tick the block advances a pattern state machine. The resulting per-LED brightness levels are rendered by a shared PWM counter, and the compared outputs are registered.

## Interface
- PWM_BITS, default 4: width of each LED brightness level and of the PWM counter. MAX = 2^PWM_BITS−1.
- CLKIN  in  1  system clock; all logic is on its rising edge.
- RESET  in  1  asynchronous, active-high reset.
- TICK  in  1  step strobe, one cycle wide; driven by the prescaler counter COUT.
- MODE  in  2  requested pattern: 0 OFF, 1 BLINK, 2 CHASE, 3 BOUNCE.
- D2  out  1  LED 0, PWM output, registered.
- D3  out  1  LED 1, PWM output, registered.
- D4  out  1  LED 2, PWM output, registered.
- D5  out  1  LED 3, PWM output, registered.

## Operation
State registers:
- mode_q: 2 bits.
- pos: 2 bits.
- dir: 1 bit, up/down.
- phase: 1 bit.
- level[0..3]: PWM_BITS each.
- pwm_cnt: PWM_BITS.

Reset values:
- All state registers are 0. mode_q = OFF, dir = up.
- D2–D5 are 0.

PWM:
- pwm_cnt increments every cycle and wraps from MAX to 0.
- Each cycle, D(n) is registered as (level[n] > pwm_cnt).
- Level 0 gives a constant 0. Level MAX gives MAX out of 2^PWM_BITS cycles high.

Cycles without TICK: all pattern state holds.

On a TICK cycle, if MODE ≠ mode_q (mode change):
- mode_q ← MODE, pos ← 0, dir ← up, phase ← 0.
- All levels ← 0.
- No pattern step is taken on this tick.

On a TICK cycle, if MODE = mode_q, by mode_q:
- OFF: all levels ← 0.
- BLINK: phase ← ~phase. All levels ← MAX if the new phase is 1, else 0.
- CHASE: pos ← pos+1, wrapping 3→0. level[new pos] ← MAX; all other levels ← 0.
- BOUNCE:
  - pos steps by dir. At pos 3 with dir up, dir flips and pos becomes 2. At pos 0 with dir down, dir flips and pos becomes 1. Sequence from reset: 1,2,3,2,1,0,1,…
  - level[new pos] ← MAX.
  - Every other LED: level ← level >> 1 (fading tail).

Boundary conditions:
- MODE changes between ticks: ignored until the next TICK.
- TICK held high continuously: every cycle is a step.
- RESET asserted mid-pattern: all state returns to reset values immediately (asynchronous). The first TICK after release steps as OFF with no mode change unless MODE ≠ 0.
- TICK coincident with RESET: RESET wins.

## Timing
- Tick to level: a TICK sampled at edge t updates level at edge t.
- Level to output: D reflects the new level from edge t+1, so LEDs change one cycle after the tick edge.
- PWM period: 2^PWM_BITS cycles. No relation between tick and PWM phase is required.
- No handshake: TICK is fire-and-forget, and the block is always ready.
- Critical path: the 4-way compare and the BOUNCE shift. No multi-cycle paths.

## Structure
- Package led_seq_pkg holds:
  - mode constants MODE_OFF, MODE_BLINK, MODE_CHASE, MODE_BOUNCE (2-bit);
  - NUM_LEDS = 4;
  - dir constants DIR_UP, DIR_DOWN.
- Sub-module led_pwm_channel, instantiated 4 times. It takes level and pwm_cnt and produces the registered compare output, with async reset to 0.
- The top level holds the pattern FSM, pwm_cnt and the level registers.

## Test plan
- Reset with TICK pulsing and MODE=0: D2–D5 stay 0 for 64 cycles; pwm_cnt counts 0..15.
- Blink, PWM_BITS=4, MODE=1:
  - First TICK latches the mode and leaves all levels at 0.
  - Second TICK sets all levels to 15; each LED is then high 15 of every 16 cycles, starting one cycle after the tick edge.
  - Third TICK sets all levels to 0.
- CHASE, MODE=2, 6 ticks after latch: level MAX moves through LED 1,2,3,0,1,2; exactly one nonzero level at a time.
- BOUNCE, MODE=3, 4 ticks after latch: levels go [0,15,0,0] → [0,7,15,0] → [0,3,7,15] → [0,1,15,7]; dir flips at pos 3.
- Mid-pattern switch: in CHASE at pos 2, change MODE to 1 between ticks.
  - No change until the next TICK.
  - That TICK zeroes all levels and sets pos 0.
  - The following TICK lights all LEDs.
- Async reset: assert RESET for 1 cycle mid-BOUNCE, off a clock edge. Outputs drop to 0 before the next edge, and the state equals the reset values.
